led_pattern_gen: RTL and testbench



---
 rtl/led_pkg.sv | 30 +++
 rtl/led_pattern_gen_if.sv | 29 ++
 rtl/led_tick_div.sv | 48 ++++
 rtl/led_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_led_pattern_gen.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the decorative LED pattern generator:
//   - mode encodings driven by the mode-select stage
//   - pattern FSM state enumeration
//   - active_rule encodings reported back on the LED bus
// ---------------------------------------------------------------------------
package led_pkg;

  // Mode encodings as presented on mode_in
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_RULE1 = 2'b01;
  localparam logic [1:0] MODE_RULE2 = 2'b10;
  localparam logic [1:0] MODE_AUTO  = 2'b11;

  // Rule currently shown on the LED bank
  localparam logic [1:0] RULE_NONE = 2'b00;
  localparam logic [1:0] RULE_1    = 2'b01;
  localparam logic [1:0] RULE_2    = 2'b10;

  // Pattern sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RULE1   = 3'd1,
    ST_RULE2   = 3'd2,
    ST_AUTO_R1 = 3'd3,
    ST_AUTO_R2 = 3'd4
  } led_state_e;

endpackage : led_pkg

// File: rtl/led_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// led_pattern_gen_if
// Bundles the mode request and the LED-bank outputs of led_pattern_gen.
//   mode_in     : requested mode (00 idle, 01 rule 1, 10 rule 2, 11 auto)
//   leds        : LED drive, bit 0 = leftmost LED
//   active_rule : rule currently displayed (00 none, 01 rule 1, 10 rule 2)
//   step_tick   : one-cycle pulse when the pattern step advances
//   cycle_done  : one-cycle pulse when the step wraps from last to 0
// master = mode-select side, slave = pattern generator.
// ---------------------------------------------------------------------------
interface led_pattern_gen_if #(
  parameter int NUM_LEDS = 16
);
  logic [1:0]          mode_in;
  logic [NUM_LEDS-1:0] leds;
  logic [1:0]          active_rule;
  logic                step_tick;
  logic                cycle_done;

  modport master (
    output mode_in,
    input  leds, active_rule, step_tick, cycle_done
  );

  modport slave (
    input  mode_in,
    output leds, active_rule, step_tick, cycle_done
  );
endinterface : led_pattern_gen_if

// File: rtl/led_tick_div.sv
// ---------------------------------------------------------------------------
// led_tick_div
// Step prescaler. Counts clk cycles while enabled and flags the last cycle
// of each TICK_DIV-cycle step window.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clear  : restart the count from 0 (mode change)
//   enable : count only while a pattern is running; held at 0 otherwise
//   tick   : high while the count sits at TICK_DIV-1 (step advances at the
//            following edge)
// ---------------------------------------------------------------------------
module led_tick_div #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clear || !enable) begin
      div_d = '0;
    end else if (div_q == DIV_MAX) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = enable && (div_q == DIV_MAX);

endmodule : led_tick_div

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Drives the decorative LED bank from the registered 2-bit mode:
//   00 idle (all off), 01 repeat rule 1 (fill/drain), 10 repeat rule 2
//   (bounce dot), 11 automatic (AUTO_REPEATS cycles of each rule in turn).
// Each pattern step is held TICK_DIV cycles; any mode change restarts the
// sequence at step 0 with a one-clock latency.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : led_pattern_gen_if slave (mode_in in; leds, active_rule,
//           step_tick, cycle_done out, all registered)
// ---------------------------------------------------------------------------
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 16,
  parameter int TICK_DIV     = 5000000,
  parameter int AUTO_REPEATS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  led_pattern_gen_if.slave    bus
);

  localparam int L1     = 2 * NUM_LEDS;
  localparam int L2     = 2 * NUM_LEDS - 2;
  localparam int STEP_W = $clog2(2 * NUM_LEDS);
  localparam int REP_W  = (AUTO_REPEATS > 1) ? $clog2(AUTO_REPEATS) : 1;

  localparam logic [STEP_W-1:0] L1_LAST  = STEP_W'(L1 - 1);
  localparam logic [STEP_W-1:0] L2_LAST  = STEP_W'(L2 - 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(AUTO_REPEATS - 1);

  // Rule 1: fill from bit 0 upwards, then drain from the top.
  function automatic logic [NUM_LEDS-1:0] rule1_pat(input logic [STEP_W-1:0] k);
    logic [NUM_LEDS-1:0] ones;
    int                  ki;
    ones = '1;
    ki   = int'(k);
    if (ki < NUM_LEDS) begin
      rule1_pat = ones >> (NUM_LEDS - 1 - ki);
    end else begin
      // Last step shifts by NUM_LEDS, giving an all-off frame.
      rule1_pat = ones >> (ki - NUM_LEDS + 1);
    end
  endfunction

  // Rule 2: single dot walking out to the far end and back, ends not repeated.
  function automatic logic [NUM_LEDS-1:0] rule2_pat(input logic [STEP_W-1:0] k);
    logic [NUM_LEDS-1:0] one;
    int                  ki;
    one = NUM_LEDS'(1);
    ki  = int'(k);
    if (ki < NUM_LEDS) begin
      rule2_pat = one << ki;
    end else begin
      rule2_pat = one << (2 * NUM_LEDS - 2 - ki);
    end
  endfunction

  led_state_e          state_q;
  logic [1:0]          mode_q;
  logic [STEP_W-1:0]   step_q;
  logic [REP_W-1:0]    rep_q;
  logic [NUM_LEDS-1:0] leds_q;
  logic [1:0]          active_rule_q;
  logic                step_tick_q;
  logic                cycle_done_q;

  logic                mode_change;
  logic                running;
  logic                tick;
  logic                is_rule2;
  logic                is_auto;
  logic                wrap;
  logic                rep_last;
  logic [STEP_W-1:0]   step_inc;

  always_comb begin
    mode_change = (bus.mode_in != mode_q);
    running     = (state_q != ST_IDLE);
    is_rule2    = (state_q == ST_RULE2) || (state_q == ST_AUTO_R2);
    is_auto     = (state_q == ST_AUTO_R1) || (state_q == ST_AUTO_R2);
    wrap        = is_rule2 ? (step_q == L2_LAST) : (step_q == L1_LAST);
    rep_last    = (rep_q == REP_LAST);
    step_inc    = step_q + 1'b1;
  end

  led_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (mode_change),
    .enable (running),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_IDLE;
      step_q        <= '0;
      rep_q         <= '0;
      leds_q        <= '0;
      active_rule_q <= RULE_NONE;
      step_tick_q   <= 1'b0;
      cycle_done_q  <= 1'b0;
    end else begin
      step_tick_q  <= 1'b0;
      cycle_done_q <= 1'b0;
      if (mode_change) begin
        // A mode change wins over a coincident tick: restart silently.
        mode_q <= bus.mode_in;
        step_q <= '0;
        rep_q  <= '0;
        case (bus.mode_in)
          MODE_RULE1: begin
            state_q       <= ST_RULE1;
            leds_q        <= rule1_pat('0);
            active_rule_q <= RULE_1;
          end
          MODE_RULE2: begin
            state_q       <= ST_RULE2;
            leds_q        <= rule2_pat('0);
            active_rule_q <= RULE_2;
          end
          MODE_AUTO: begin
            state_q       <= ST_AUTO_R1;
            leds_q        <= rule1_pat('0);
            active_rule_q <= RULE_1;
          end
          default: begin
            state_q       <= ST_IDLE;
            leds_q        <= '0;
            active_rule_q <= RULE_NONE;
          end
        endcase
      end else if (running && tick) begin
        step_tick_q <= 1'b1;
        if (wrap) begin
          cycle_done_q <= 1'b1;
          step_q       <= '0;
          if (is_auto && rep_last) begin
            // Enough full cycles of this rule: hand over to the other one.
            rep_q <= '0;
            if (state_q == ST_AUTO_R1) begin
              state_q       <= ST_AUTO_R2;
              leds_q        <= rule2_pat('0);
              active_rule_q <= RULE_2;
            end else begin
              state_q       <= ST_AUTO_R1;
              leds_q        <= rule1_pat('0);
              active_rule_q <= RULE_1;
            end
          end else begin
            if (is_auto) begin
              rep_q <= rep_q + 1'b1;
            end
            leds_q <= is_rule2 ? rule2_pat('0) : rule1_pat('0);
          end
        end else begin
          step_q <= step_inc;
          leds_q <= is_rule2 ? rule2_pat(step_inc) : rule1_pat(step_inc);
        end
      end
    end
  end

  assign bus.leds        = leds_q;
  assign bus.active_rule = active_rule_q;
  assign bus.step_tick   = step_tick_q;
  assign bus.cycle_done  = cycle_done_q;

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Drives mode sequences (directed then random) into led_pattern_gen with
// NUM_LEDS=8, TICK_DIV=4, AUTO_REPEATS=2. The reference model counts clock
// edges since the last mode change and looks the expected frame up in a
// table of whole pattern sequences (rule 1, rule 2, and the combined
// automatic sequence), so every output is checked on every cycle.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int N  = 8;
  localparam int TD = 4;
  localparam int AR = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  led_pattern_gen_if #(.NUM_LEDS(N)) bus ();

  led_pattern_gen #(
    .NUM_LEDS     (N),
    .TICK_DIV     (TD),
    .AUTO_REPEATS (AR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Sequence tables: index 0 = rule 1, 1 = rule 2, 2 = automatic.
  int seq_leds [3][60];
  int seq_rule [3][60];
  bit seq_wrap [3][60];
  int seq_len  [3];

  // Model state: accepted mode and edges elapsed since it was accepted.
  int m_mode;
  int m_n;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    int exp_leds, exp_rule, exp_tick, exp_done;
    int idx, s, p;
    exp_leds = 0; exp_rule = 0; exp_tick = 0; exp_done = 0;
    if (m_mode != 0) begin
      idx      = m_mode - 1;
      s        = m_n / TD;
      p        = s % seq_len[idx];
      exp_leds = seq_leds[idx][p];
      exp_rule = seq_rule[idx][p];
      exp_tick = (m_n > 0 && (m_n % TD) == 0) ? 1 : 0;
      exp_done = (exp_tick == 1 && seq_wrap[idx][p]) ? 1 : 0;
    end
    chk("leds",        32'(bus.leds),        32'(exp_leds));
    chk("active_rule", 32'(bus.active_rule), 32'(exp_rule));
    chk("step_tick",   32'(bus.step_tick),   32'(exp_tick));
    chk("cycle_done",  32'(bus.cycle_done),  32'(exp_done));
  endtask

  // One clock: update the model from the mode seen at the edge, then check.
  task automatic cyc(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      if (rst_n) begin
        if (int'(bus.mode_in) != m_mode) begin
          m_mode = int'(bus.mode_in);
          m_n    = 0;
        end else begin
          m_n++;
        end
      end
      #1;
      check_all();
    end
  endtask

  // Called 1 time unit after a rising edge; asserts reset mid-cycle.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    m_mode = 0;
    m_n    = 0;
    #1;
    chk("async_rst_leds", 32'(bus.leds),        32'd0);
    chk("async_rst_rule", 32'(bus.active_rule), 32'd0);
    chk("async_rst_tick", 32'(bus.step_tick),   32'd0);
    chk("async_rst_done", 32'(bus.cycle_done),  32'd0);
    cyc(2);
    #4 rst_n = 1'b1;
  endtask

  task automatic run_mode(input string name, input logic [1:0] mode, input int count);
    bus.mode_in = mode;
    cyc(count);
    $display("txn %-12s mode=%b cycles=%0d leds=%h rule=%b checks=%0d", name, mode, count,
             bus.leds, bus.active_rule, n_cmp);
  endtask

  initial begin
    // Build the expected sequences straight from the pattern rules.
    for (int k = 0; k < 2 * N; k++) begin
      int v;
      v = (k < N) ? ((1 << (k + 1)) - 1) : (((1 << N) - 1) >> (k - N + 1));
      seq_leds[0][k] = v;          seq_rule[0][k] = 1;
      seq_leds[2][k] = v;          seq_rule[2][k] = 1;
      seq_leds[2][2*N + k] = v;    seq_rule[2][2*N + k] = 1;
    end
    for (int k = 0; k < 2 * N - 2; k++) begin
      int v;
      v = (k < N) ? (1 << k) : (1 << (2 * N - 2 - k));
      seq_leds[1][k] = v;                       seq_rule[1][k] = 2;
      seq_leds[2][4*N + k] = v;                 seq_rule[2][4*N + k] = 2;
      seq_leds[2][4*N + (2*N - 2) + k] = v;     seq_rule[2][4*N + (2*N - 2) + k] = 2;
    end
    seq_len[0] = 2 * N;
    seq_len[1] = 2 * N - 2;
    seq_len[2] = AR * (2 * N) + AR * (2 * N - 2);
    for (int i = 0; i < 60; i++) begin
      seq_wrap[0][i] = (i == 0);
      seq_wrap[1][i] = (i == 0);
      seq_wrap[2][i] = (i == 0) || (i == 2 * N) || (i == 4 * N) || (i == 4 * N + 2 * N - 2);
    end

    m_mode      = 0;
    m_n         = 0;
    rst_n       = 1'b0;
    bus.mode_in = 2'b00;

    #12;
    chk("reset_leds", 32'(bus.leds),        32'd0);
    chk("reset_rule", 32'(bus.active_rule), 32'd0);
    chk("reset_tick", 32'(bus.step_tick),   32'd0);
    chk("reset_done", 32'(bus.cycle_done),  32'd0);
    rst_n = 1'b1;
    cyc(2);
    $display("txn reset        leds=%h rule=%b checks=%0d", bus.leds, bus.active_rule, n_cmp);

    // Rule 1 through a full cycle and its wrap.
    run_mode("rule1", 2'b01, 70);
    // Idle while running: quiet for 50 clocks.
    run_mode("idle", 2'b00, 50);
    // Rule 2 from idle through its wrap.
    run_mode("rule2", 2'b10, 64);
    run_mode("idle", 2'b00, 3);
    // Automatic: both rules, both switches, and back to rule 1.
    run_mode("auto", 2'b11, 260);
    // Mode change coincident with a pending tick (rule 1 step 5, div 3).
    run_mode("rule1_to_5", 2'b01, 24);
    run_mode("rule2_prio", 2'b10, 10);
    // Auto to step 4 (1F), then asynchronous reset mid-pattern.
    run_mode("auto_to_1f", 2'b11, 18);
    pulse_reset();
    $display("txn async_reset  leds=%h rule=%b checks=%0d", bus.leds, bus.active_rule, n_cmp);
    run_mode("auto_resume", 2'b11, 30);

    // Random mode sequences with occasional reset pulses.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] md;
      int         len;
      md  = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 80));
      run_mode("random", md, len);
      if ($urandom_range(0, 9) == 0) begin
        pulse_reset();
        $display("txn rand_reset   leds=%h rule=%b checks=%0d", bus.leds, bus.active_rule, n_cmp);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_led_pattern_gen
